// File: rtl/easy_fifo_pkg.sv
// Shared helpers for the easy_fifo AXI-Stream blocks.
// Lane-counter sizing and lane decoding.
package easy_fifo_pkg;

   function automatic int cnt_width(input int ratio);
      int w;
      w = $clog2(ratio);
      return (w < 1) ? 1 : w;
   endfunction

   function automatic logic lane_hit(input int cnt, input int lane);
      return cnt == lane;
   endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// One-deep registered AXI-Stream slice.
// out_free tells the producer a new beat may be loaded this cycle.
module axis_reg_slice #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             out_free,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
);

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;

   assign out_free  = ~valid_q | out_ready;
   assign out_valid = valid_q;
   assign out_data  = data_q;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (out_free) begin
         valid_d = in_valid;
         if (in_valid) data_d = in_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: rtl/easy_fifo_axis_upsizer.sv
// Packs RATIO narrow AXI-Stream beats into one wide beat.
// Early tlast flushes a partial word with per-lane tkeep.
module easy_fifo_axis_upsizer
   import easy_fifo_pkg::*;
#(
   parameter int DWIDTH = 32,
   parameter int RATIO  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [DWIDTH-1:0]        s_axis_tdata,
   input  logic                     s_axis_tvalid,
   input  logic                     s_axis_tlast,
   output logic                     s_axis_tready,
   output logic [DWIDTH*RATIO-1:0]  m_axis_tdata,
   output logic [RATIO-1:0]         m_axis_tkeep,
   output logic                     m_axis_tlast,
   output logic                     m_axis_tvalid,
   input  logic                     m_axis_tready
);

   localparam int CW = cnt_width(RATIO);
   localparam int WW = DWIDTH * RATIO;
   localparam int SW = WW + RATIO + 1;

   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WW-1:0]    acc_q, acc_d, word;
   logic [RATIO-1:0] keep_q, keep_d, word_keep, lane_oh;
   logic             out_free, accept, complete;
   logic [SW-1:0]    slice_in, slice_out;

   assign s_axis_tready = out_free & ~rst;
   assign accept        = s_axis_tvalid & s_axis_tready;
   assign complete      = accept &
                          (s_axis_tlast | (cnt_q == CW'(RATIO - 1)));

   // Word as it would look with the current beat merged in lane cnt.
   always_comb begin
      word = acc_q;
      for (int i = 0; i < RATIO; i++) begin
         lane_oh[i] = lane_hit(int'(cnt_q), i);
         if (lane_oh[i]) word[i*DWIDTH +: DWIDTH] = s_axis_tdata;
      end
      word_keep = keep_q | lane_oh;
   end

   always_comb begin
      cnt_d  = cnt_q;
      acc_d  = acc_q;
      keep_d = keep_q;
      if (complete) begin
         cnt_d  = '0;
         acc_d  = '0;
         keep_d = '0;
      end else if (accept) begin
         cnt_d  = cnt_q + 1'b1;
         acc_d  = word;
         keep_d = word_keep;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         acc_q  <= '0;
         keep_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         acc_q  <= acc_d;
         keep_q <= keep_d;
      end
   end

   assign slice_in = {s_axis_tlast, word_keep, word};

   axis_reg_slice #(
      .WIDTH (SW)
   ) u_out (
      .clk       (clk),
      .rst       (rst),
      .in_data   (slice_in),
      .in_valid  (complete),
      .out_free  (out_free),
      .out_data  (slice_out),
      .out_valid (m_axis_tvalid),
      .out_ready (m_axis_tready)
   );

   assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = slice_out;

endmodule

// File: tb/tb_easy_fifo_axis_upsizer.sv
// Bench for easy_fifo_axis_upsizer: 8x4 packing and a RATIO=1
// slice under random handshakes, checked against a queue model.
module tb_easy_fifo_axis_upsizer;

   logic        clk = 1'b0;
   logic        rst;

   logic [7:0]  s_tdata;
   logic        s_tvalid, s_tlast, s_tready;
   logic [31:0] m_tdata;
   logic [3:0]  m_tkeep;
   logic        m_tlast, m_tvalid, m_tready;

   logic [7:0]  p_sdata;
   logic        p_svalid, p_slast, p_sready;
   logic [7:0]  p_mdata;
   logic [0:0]  p_mkeep;
   logic        p_mlast, p_mvalid, p_mready;

   int n_cmp = 0;
   int n_bad = 0;
   int stalls = 0;
   int wide_cnt = 0;

   logic [36:0] exp_q[$];
   logic [8:0]  exp1_q[$];

   logic [31:0] m_acc;
   logic [3:0]  m_keep;
   int          m_cnt;
   logic        p_done;

   always #5 clk = ~clk;

   easy_fifo_axis_upsizer #(.DWIDTH(8), .RATIO(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .s_axis_tdata  (s_tdata),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tlast  (s_tlast),
      .s_axis_tready (s_tready),
      .m_axis_tdata  (m_tdata),
      .m_axis_tkeep  (m_tkeep),
      .m_axis_tlast  (m_tlast),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready)
   );

   easy_fifo_axis_upsizer #(.DWIDTH(8), .RATIO(1)) dut1 (
      .clk           (clk),
      .rst           (rst),
      .s_axis_tdata  (p_sdata),
      .s_axis_tvalid (p_svalid),
      .s_axis_tlast  (p_slast),
      .s_axis_tready (p_sready),
      .m_axis_tdata  (p_mdata),
      .m_axis_tkeep  (p_mkeep),
      .m_axis_tlast  (p_mlast),
      .m_axis_tvalid (p_mvalid),
      .m_axis_tready (p_mready)
   );

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      m_acc  = '0;
      m_keep = '0;
      m_cnt  = 0;
   endtask

   task automatic model_beat(input logic [7:0] d, input logic l);
      m_acc[m_cnt*8 +: 8] = d;
      m_keep[m_cnt]       = 1'b1;
      if (m_cnt == 3 || l) begin
         exp_q.push_back({l, m_keep, m_acc});
         model_clear();
      end else begin
         m_cnt++;
      end
   endtask

   task automatic send(input logic [7:0] d, input logic l);
      int w;
      s_tdata  = d;
      s_tlast  = l;
      s_tvalid = 1'b1;
      w = 0;
      @(negedge clk);
      while (!s_tready && w < 1000) begin
         w++;
         @(negedge clk);
      end
      if (w >= 1000) check("send_timeout", 64'd0, 64'd1);
      if (w != 0) stalls++;
      model_beat(d, l);
      @(posedge clk);
      #1;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      logic [36:0] e;
      if (!rst && m_tvalid && m_tready) begin
         wide_cnt++;
         if (exp_q.size() == 0) begin
            check("spurious_wide", 64'd1, 64'd0);
         end else begin
            e = exp_q.pop_front();
            check("wide_data", 64'(m_tdata), 64'(e[31:0]));
            check("wide_keep", 64'(m_tkeep), 64'(e[35:32]));
            check("wide_last", 64'(m_tlast), 64'(e[36]));
         end
      end
   end

   always @(negedge clk) begin
      logic [8:0] e;
      if (!rst && p_mvalid && p_mready) begin
         if (exp1_q.size() == 0) begin
            check("spurious_r1", 64'd1, 64'd0);
         end else begin
            e = exp1_q.pop_front();
            check("r1_data", 64'(p_mdata), 64'(e[7:0]));
            check("r1_keep", 64'(p_mkeep), 64'd1);
            check("r1_last", 64'(p_mlast), 64'(e[8]));
         end
      end
   end

   initial begin
      rst = 1'b1;
      s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
      p_sdata = '0; p_svalid = 1'b0; p_slast = 1'b0; p_mready = 1'b1;
      p_done = 1'b0;
      model_clear();
      repeat (3) @(negedge clk);
      check("rst_m_valid", 64'(m_tvalid), 64'd0);
      check("rst_m_data", 64'(m_tdata), 64'd0);
      check("rst_m_keep", 64'(m_tkeep), 64'd0);
      check("rst_m_last", 64'(m_tlast), 64'd0);
      check("rst_s_ready", 64'(s_tready), 64'd0);
      check("rst_r1_ready", 64'(p_sready), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      idle(2);

      // full word
      send(8'h11, 1'b0);
      send(8'h22, 1'b0);
      send(8'h33, 1'b0);
      check("no_early_valid", 64'(m_tvalid), 64'd0);
      send(8'h44, 1'b0);
      @(negedge clk);
      check("t1_valid", 64'(m_tvalid), 64'd1);
      check("t1_data", 64'(m_tdata), 64'h44332211);
      @(negedge clk);
      check("t1_pulse", 64'(m_tvalid), 64'd0);
      idle(1);

      // early tlast, then a fresh word in lane 0
      send(8'hA1, 1'b0);
      send(8'hA2, 1'b1);
      @(negedge clk);
      check("t2_keep", 64'(m_tkeep), 64'h3);
      check("t2_data", 64'(m_tdata), 64'h0000A2A1);
      idle(1);

      // 12-beat stream, last on the 4th beat of the final word
      stalls = 0;
      for (int i = 0; i < 12; i++) send(8'(8'hB0 + i), i == 11);
      check("stream_stalls", 64'(stalls), 64'd0);
      idle(3);

      // output hold under backpressure
      m_tready = 1'b0;
      send(8'h55, 1'b0);
      send(8'h66, 1'b0);
      send(8'h77, 1'b0);
      send(8'h88, 1'b0);
      s_tdata = 8'h99; s_tlast = 1'b0; s_tvalid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_s_ready", 64'(s_tready), 64'd0);
         check("hold_valid", 64'(m_tvalid), 64'd1);
         check("hold_data", 64'(m_tdata), 64'h88776655);
      end
      @(posedge clk); #1;
      m_tready = 1'b1;
      send(8'h99, 1'b0);
      send(8'hAA, 1'b0);
      send(8'hBB, 1'b0);
      send(8'hCC, 1'b1);
      idle(3);

      // reset mid-word
      send(8'h01, 1'b0);
      send(8'h02, 1'b0);
      rst = 1'b1;
      model_clear();
      #1;
      check("midrst_s_ready", 64'(s_tready), 64'd0);
      check("midrst_valid", 64'(m_tvalid), 64'd0);
      idle(2);
      rst = 1'b0;
      idle(1);
      send(8'hD1, 1'b0);
      send(8'hD2, 1'b0);
      send(8'hD3, 1'b0);
      send(8'hD4, 1'b0);
      @(negedge clk);
      check("midrst_data", 64'(m_tdata), 64'hD4D3D2D1);
      check("midrst_keep", 64'(m_tkeep), 64'hF);
      idle(3);

      // RATIO=1 under random valid/ready
      fork
         begin
            for (int n = 0; n < 200; n++) begin
               int w;
               logic [7:0] d;
               logic l;
               p_svalid = 1'b0;
               idle($urandom_range(0, 2));
               d = 8'($urandom);
               l = 1'($urandom);
               p_sdata = d; p_slast = l; p_svalid = 1'b1;
               w = 0;
               @(negedge clk);
               while (!p_sready && w < 1000) begin
                  w++;
                  @(negedge clk);
               end
               if (w >= 1000) check("r1_timeout", 64'd0, 64'd1);
               exp1_q.push_back({l, d});
               @(posedge clk); #1;
            end
            p_svalid = 1'b0;
            p_done = 1'b1;
         end
         begin
            while (!p_done) begin
               p_mready = 1'($urandom);
               @(posedge clk); #1;
            end
            p_mready = 1'b1;
         end
      join
      idle(5);

      check("r1_queue_empty", 64'(exp1_q.size()), 64'd0);
      check("wide_queue_empty", 64'(exp_q.size()), 64'd0);
      check("wide_count", 64'(wide_cnt), 64'd8);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
